// File: rtl/huffman_symbol_sequencer_if.sv
// huffman_symbol_sequencer_if: block-in / symbol-out bundle for the Huffman symbol sequencer
interface huffman_symbol_sequencer_if #(
    parameter int COEF_W   = 10,
    parameter int NUM_COEF = 64,
    parameter int CID_W    = 2
);
    logic                       i_start;
    logic [CID_W-1:0]           i_comp_id;
    logic [NUM_COEF*COEF_W-1:0] i_block_in;
    logic                       i_restart;
    logic                       o_busy;
    logic                       o_sym_valid;
    logic                       i_sym_ready;
    logic                       o_sym_is_dc;
    logic [3:0]                 o_sym_run;
    logic [3:0]                 o_sym_size;
    logic [COEF_W:0]            o_sym_amp;
    logic [CID_W-1:0]           o_sym_comp;
    logic                       o_sym_last;
    logic                       o_block_done;
    modport master (
        output i_start, i_comp_id, i_block_in, i_restart, i_sym_ready,
        input  o_busy, o_sym_valid, o_sym_is_dc, o_sym_run, o_sym_size, o_sym_amp,
               o_sym_comp, o_sym_last, o_block_done
    );
    modport slave (
        input  i_start, i_comp_id, i_block_in, i_restart, i_sym_ready,
        output o_busy, o_sym_valid, o_sym_is_dc, o_sym_run, o_sym_size, o_sym_amp,
               o_sym_comp, o_sym_last, o_block_done
    );
endinterface

// File: rtl/huffman_symbol_sequencer.sv
// huffman_symbol_sequencer: turns a zigzag coefficient block into JPEG DC/AC/ZRL/EOB symbols
module huffman_symbol_sequencer #(
    parameter int COEF_W   = 10,
    parameter int NUM_COEF = 64,
    parameter int NUM_COMP = 3
) (
    input logic i_clk,
    input logic i_rst,
    huffman_symbol_sequencer_if.slave bus
);
    localparam int CID_W = (NUM_COMP > 2) ? $clog2(NUM_COMP) : 1;
    localparam int K_W   = $clog2(NUM_COEF);
    typedef enum logic [2:0] {IDLE, DC, SCAN, ZRL, AC, DONE} state_t;
    state_t                     r_state;
    logic [NUM_COEF*COEF_W-1:0] r_blk;
    logic [CID_W-1:0]           r_comp;
    logic [COEF_W-1:0]          r_pred [NUM_COMP];
    logic [K_W-1:0]             r_k;
    logic [K_W-1:0]             r_zrl;
    logic [3:0]                 r_run;
    logic                       r_busy, r_valid, r_is_dc, r_last, r_done;
    logic [3:0]                 r_sym_run, r_sym_size;
    logic [COEF_W:0]            r_sym_amp;
    logic                       w_xfer, w_k_last;
    logic [COEF_W-1:0]          w_raw, w_pred;
    logic [COEF_W:0]            w_coef, w_diff, w_ac_amp, w_dc_amp;
    logic [3:0]                 w_ac_size, w_dc_size;
    function automatic logic [3:0] f_size(input logic [COEF_W:0] v);
        logic [COEF_W:0] m;
        m = v[COEF_W] ? -v : v;
        f_size = '0;
        for (int i = 0; i <= COEF_W; i++) if (m[i]) f_size = 4'(i + 1);
    endfunction
    // negative values carry the one's-complement magnitude in the low size bits
    function automatic logic [COEF_W:0] f_amp(input logic [COEF_W:0] v, input logic [3:0] s);
        f_amp = v[COEF_W] ? (v - 1'b1) & ~({(COEF_W+1){1'b1}} << s) : v;
    endfunction
    assign w_xfer    = r_valid & bus.i_sym_ready;
    assign w_k_last  = r_k == K_W'(NUM_COEF - 1);
    assign w_raw     = r_blk[int'(r_k)*COEF_W +: COEF_W];
    assign w_coef    = {w_raw[COEF_W-1], w_raw};
    assign w_ac_size = f_size(w_coef);
    assign w_ac_amp  = f_amp(w_coef, w_ac_size);
    // a simultaneous restart clears the predictor before the new block's DC uses it
    assign w_pred    = bus.i_restart ? '0 : r_pred[bus.i_comp_id];
    assign w_diff    = {bus.i_block_in[COEF_W-1], bus.i_block_in[COEF_W-1:0]} - {w_pred[COEF_W-1], w_pred};
    assign w_dc_size = f_size(w_diff);
    assign w_dc_amp  = f_amp(w_diff, w_dc_size);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_blk      <= '0;
            r_comp     <= '0;
            for (int c = 0; c < NUM_COMP; c++) r_pred[c] <= '0;
            r_k        <= '0;
            r_zrl      <= '0;
            r_run      <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_is_dc    <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_sym_run  <= '0;
            r_sym_size <= '0;
            r_sym_amp  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                    if (bus.i_restart) for (int c = 0; c < NUM_COMP; c++) r_pred[c] <= '0;
                    if (bus.i_start) begin
                        r_blk      <= bus.i_block_in;
                        r_comp     <= bus.i_comp_id;
                        r_busy     <= 1'b1;
                        r_valid    <= 1'b1;
                        r_is_dc    <= 1'b1;
                        r_last     <= 1'b0;
                        r_sym_run  <= '0;
                        r_sym_size <= w_dc_size;
                        r_sym_amp  <= w_dc_amp;
                        r_state    <= DC;
                    end
                end
                DC: if (w_xfer) begin
                    r_pred[r_comp] <= r_blk[COEF_W-1:0];
                    r_valid        <= 1'b0;
                    r_is_dc        <= 1'b0;
                    r_k            <= K_W'(1);
                    r_run          <= '0;
                    r_zrl          <= '0;
                    r_state        <= SCAN;
                end
                SCAN: if (w_coef == '0 && !w_k_last) begin
                    r_k   <= r_k + 1'b1;
                    r_run <= r_run + 1'b1;
                    r_zrl <= r_zrl + K_W'(r_run == 4'd15);
                end else begin
                    // trailing zero gives EOB; pending ZRLs precede a nonzero coefficient
                    r_valid    <= 1'b1;
                    r_sym_run  <= w_coef == '0 ? 4'd0 : r_zrl != '0 ? 4'd15 : r_run;
                    r_sym_size <= w_coef == '0 || r_zrl != '0 ? 4'd0 : w_ac_size;
                    r_sym_amp  <= w_coef == '0 || r_zrl != '0 ? '0 : w_ac_amp;
                    r_last     <= w_k_last && (w_coef == '0 || r_zrl == '0);
                    r_state    <= w_coef != '0 && r_zrl != '0 ? ZRL : AC;
                end
                ZRL: if (w_xfer) begin
                    r_zrl <= r_zrl - 1'b1;
                    if (r_zrl == K_W'(1)) begin
                        r_sym_run  <= r_run;
                        r_sym_size <= w_ac_size;
                        r_sym_amp  <= w_ac_amp;
                        r_last     <= w_k_last;
                        r_state    <= AC;
                    end
                end
                AC: if (w_xfer) begin
                    r_valid <= 1'b0;
                    r_run   <= '0;
                    r_last  <= 1'b0;
                    r_k     <= r_last ? r_k : r_k + 1'b1;
                    r_busy  <= !r_last;
                    r_done  <= r_last;
                    r_state <= r_last ? DONE : SCAN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.o_busy       = r_busy;
    assign bus.o_sym_valid  = r_valid;
    assign bus.o_sym_is_dc  = r_is_dc;
    assign bus.o_sym_run    = r_sym_run;
    assign bus.o_sym_size   = r_sym_size;
    assign bus.o_sym_amp    = r_sym_amp;
    assign bus.o_sym_comp   = r_comp;
    assign bus.o_sym_last   = r_last;
    assign bus.o_block_done = r_done;
endmodule

// File: tb/tb_huffman_symbol_sequencer.sv
// tb_huffman_symbol_sequencer: table-driven blocks with a symbol scoreboard and corner sequences
module tb_huffman_symbol_sequencer;
    localparam int W  = 10;
    localparam int N  = 64;
    localparam int NC = 3;
    localparam int CW = 2;
    localparam int AW = W + 1;
    typedef struct {
        bit restart;
        int comp, dc, p1, v1, p2, v2, dsz, damp, stall;
        bit glitch;
    } vec_t;
    typedef struct packed {
        logic          is_dc;
        logic [3:0]    run;
        logic [3:0]    size;
        logic [AW-1:0] amp;
        logic          last;
    } sym_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    sym_t q[$];
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    huffman_symbol_sequencer_if #(.COEF_W(W), .NUM_COEF(N), .CID_W(CW)) bus ();
    huffman_symbol_sequencer #(.COEF_W(W), .NUM_COEF(N), .NUM_COMP(NC)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    function automatic sym_t mk(input logic dc, input int run, input int v, input logic last);
        int   m, s;
        sym_t r;
        m = v < 0 ? -v : v;
        s = 0;
        while (m > 0) begin s++; m = m >> 1; end
        r.is_dc = dc;
        r.run   = 4'(run);
        r.size  = 4'(s);
        r.amp   = v >= 0 ? AW'(v) : AW'((v - 1) & ((1 << s) - 1));
        r.last  = last;
        return r;
    endfunction
    function automatic sym_t cur();
        return {bus.o_sym_is_dc, bus.o_sym_run, bus.o_sym_size, bus.o_sym_amp, bus.o_sym_last};
    endfunction
    task automatic run_block(input vec_t v);
        int               c[N];
        logic [N*W-1:0]   blk;
        int               z, wait_cnt;
        bit               fresh, done;
        sym_t             snap, act, exp_s;
        c = '{default: 0};
        c[0] = v.dc;
        if (v.p1 > 0) c[v.p1] = v.v1;
        if (v.p2 > 0) c[v.p2] = v.v2;
        for (int k = 0; k < N; k++) blk[k*W +: W] = W'(c[k]);
        exp_s = '{is_dc: 1'b1, run: 4'd0, size: 4'(v.dsz), amp: AW'(v.damp), last: 1'b0};
        q.push_back(exp_s);
        z = 0;
        for (int k = 1; k < N; k++) begin
            if (c[k] == 0) z++;
            else begin
                while (z >= 16) begin q.push_back(mk(1'b0, 15, 0, 1'b0)); z -= 16; end
                q.push_back(mk(1'b0, z, c[k], k == N - 1));
                z = 0;
            end
        end
        if (c[N-1] == 0) q.push_back(mk(1'b0, 0, 0, 1'b1));
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_restart   = v.restart;
        bus.i_comp_id   = CW'(v.comp);
        bus.i_block_in  = blk;
        bus.i_sym_ready = v.stall == 0;
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_restart  = 1'b0;
        bus.i_block_in = ~blk;
        bus.i_comp_id  = CW'(v.comp + 1);
        chk("busy_after_start", 32'(bus.o_busy), 1);
        fresh = 1'b1;
        done  = 1'b0;
        wait_cnt = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (v.glitch && cyc == 2) begin bus.i_start = 1'b1; bus.i_restart = 1'b1; bus.i_comp_id = '0; end
            if (v.glitch && cyc == 3) begin bus.i_start = 1'b0; bus.i_restart = 1'b0; end
            if (bus.o_sym_valid) begin
                act = cur();
                if (fresh) begin snap = act; wait_cnt = v.stall; fresh = 1'b0; end
                else chk("hold_stable", 32'(act), 32'(snap));
                if (wait_cnt > 0) begin
                    bus.i_sym_ready = 1'b0;
                    wait_cnt--;
                end else begin
                    bus.i_sym_ready = 1'b1;
                    fresh = 1'b1;
                    if (q.size() == 0) chk("extra_symbol", 32'(act), 0);
                    else begin
                        exp_s = q.pop_front();
                        chk("symbol", 32'(act), 32'(exp_s));
                        chk("sym_comp", 32'(bus.o_sym_comp), 32'(v.comp));
                        done = exp_s.last;
                    end
                end
            end
        end
        if (!done) chk("block_timeout", 0, 1);
        @(negedge clk);
        chk("block_done_pulse", 32'(bus.o_block_done), 1);
        chk("busy_cleared", 32'(bus.o_busy), 0);
        chk("queue_empty", 32'(q.size()), 0);
        q.delete();
        @(negedge clk);
        chk("block_done_single", 32'(bus.o_block_done), 0);
        chk("idle_no_symbol", 32'(bus.o_sym_valid), 0);
    endtask
    initial begin
        vec_t r;
        bus.i_start = 1'b0; bus.i_restart = 1'b0; bus.i_comp_id = '0;
        bus.i_block_in = '0; bus.i_sym_ready = 1'b0;
        tbl[0] = '{0, 0, 12,   0,    0,  0,   0,  4,   12, 0, 0};
        tbl[1] = '{0, 0, 5,    0,    0,  0,   0,  3,    0, 0, 0};
        tbl[2] = '{0, 1, 5,    0,    0,  0,   0,  3,    5, 0, 0};
        tbl[3] = '{1, 0, 5,    0,    0,  0,   0,  3,    5, 0, 0};
        tbl[4] = '{0, 2, -3,   1,   -1, 20,   3,  2,    0, 0, 0};
        tbl[5] = '{1, 0, 0,    63,   1,  0,   0,  0,    0, 0, 0};
        tbl[6] = '{0, 2, -3,   5, -200, 40, 511,  2,    0, 5, 0};
        tbl[7] = '{0, 1, -512, 63, -512, 0,   0, 10,  511, 5, 1};
        tbl[8] = '{0, 1, 511,  16,   7,  0,   0, 10, 1023, 0, 0};
        tbl[9] = '{0, 0, 0,    17,  -1,  0,   0,  0,    0, 0, 0};
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(bus.o_busy), 0);
        chk("rst_valid", 32'(bus.o_sym_valid), 0);
        chk("rst_is_dc", 32'(bus.o_sym_is_dc), 0);
        chk("rst_run",   32'(bus.o_sym_run), 0);
        chk("rst_size",  32'(bus.o_sym_size), 0);
        chk("rst_amp",   32'(bus.o_sym_amp), 0);
        chk("rst_comp",  32'(bus.o_sym_comp), 0);
        chk("rst_last",  32'(bus.o_sym_last), 0);
        chk("rst_done",  32'(bus.o_block_done), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) run_block(tbl[i]);
        // abort mid-block: the pending DC symbol vanishes and predictors clear
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_comp_id = '0; bus.i_sym_ready = 1'b0;
        bus.i_block_in = '0; bus.i_block_in[W-1:0] = W'(100);
        @(negedge clk);
        bus.i_start = 1'b0;
        chk("abort_valid_before", 32'(bus.o_sym_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(bus.o_sym_valid), 0);
        chk("abort_busy",  32'(bus.o_busy), 0);
        chk("abort_is_dc", 32'(bus.o_sym_is_dc), 0);
        chk("abort_size",  32'(bus.o_sym_size), 0);
        @(negedge clk);
        chk("abort_no_done", 32'(bus.o_block_done), 0);
        rst = 1'b0;
        r = '{0, 0, 7, 0, 0, 0, 0, 3, 7, 0, 0};
        run_block(r);
        r = '{0, 1, -6, 0, 0, 0, 0, 3, 1, 2, 0};
        run_block(r);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
